// File: rtl/alu_logic_pkg.sv
// Shared types and defaults for the ALU bitwise logic unit.
package alu_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } logic_op_e;

  localparam int LOGIC_W_DEFAULT = 8;

endpackage

// File: rtl/alu_logic_unit_if.sv
// Operand/result bundle between the ALU front end and the logic unit.
// ALU_LOGIC_PARITY_EN adds the registered parity flag to the bundle.
interface alu_logic_unit_if #(
  parameter int WIDTH = alu_logic_pkg::LOGIC_W_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       S;
  logic             out_valid;
  logic [WIDTH-1:0] OUT;
  logic             zero;

`ifdef ALU_LOGIC_PARITY_EN
  logic             parity;

  modport master (output in_valid, A, B, S, input out_valid, OUT, zero, parity);
  modport slave  (input in_valid, A, B, S, output out_valid, OUT, zero, parity);
`else
  modport master (output in_valid, A, B, S, input out_valid, OUT, zero);
  modport slave  (input in_valid, A, B, S, output out_valid, OUT, zero);
`endif

endinterface

// File: rtl/alu_logic_core.sv
// Combinational bitwise function of opcode and operands; no state.
module alu_logic_core
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = LOGIC_W_DEFAULT
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = ~a;
    case (logic_op_e'(s))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      // An unknown opcode falls through to NOT.
      default: result = ~a;
    endcase
  end

endmodule

// File: rtl/alu_logic_unit.sv
// Registered bitwise logic unit: one-cycle latency, valid in/out, zero flag.
// Define ALU_LOGIC_PARITY_EN to also register the result parity.
module alu_logic_unit
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = LOGIC_W_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  alu_logic_unit_if.slave bus
);

  logic [WIDTH-1:0] result;

  alu_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .s      (bus.S),
    .a      (bus.A),
    .b      (bus.B),
    .result (result)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.OUT       <= '0;
      bus.zero      <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.OUT  <= result;
        bus.zero <= (result == '0);
      end
    end
  end

`ifdef ALU_LOGIC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.parity <= 1'b0;
    end else if (bus.in_valid) begin
      bus.parity <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_alu_logic_unit.sv
// Self-checking bench for alu_logic_unit: directed cases then random ops
// against a truth-table reference model.
module tb_alu_logic_unit;
  import alu_logic_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_logic_unit_if #(.WIDTH(W)) bus ();

  alu_logic_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show after the latest edge.
  logic [W-1:0] m_out    = '0;
  logic         m_zero   = 1'b1;
  logic         m_valid  = 1'b0;
  logic         m_parity = 1'b0;

  // Each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_op(input logic [1:0] s,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [3:0]   tt [4];
    logic [W-1:0] r;
    logic [3:0]   row;
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;
    tt[2] = 4'b0110;
    tt[3] = 4'b0011;
    row   = tt[s];
    for (int i = 0; i < W; i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, "_out"},   32'(bus.OUT),       32'(m_out));
    check({tag, "_zero"},  32'(bus.zero),      32'(m_zero));
`ifdef ALU_LOGIC_PARITY_EN
    check({tag, "_parity"}, 32'(bus.parity),   32'(m_parity));
`endif
  endtask

  task automatic model_reset();
    m_out    = '0;
    m_zero   = 1'b1;
    m_valid  = 1'b0;
    m_parity = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, update model, compare.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] s, input string tag);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.S        = s;
    @(posedge clk);
    #1;
    m_valid = v;
    if (v) begin
      m_out    = ref_op(s, a, b);
      m_zero   = (m_out == '0);
      m_parity = ($countones(m_out) % 2) == 1;
    end
    check_outputs(tag);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.S        = 2'b00;

    // Outputs held at reset values across edges while rst_n is low.
    #22;
    check_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 8'd10, 8'd10, 2'd0, "and");
    check("and_const", 32'(bus.OUT), 32'd10);
    step(1'b1, 8'd20, 8'd10, 2'd1, "or");
    check("or_const", 32'(bus.OUT), 32'd30);
    step(1'b1, 8'd3, 8'd5, 2'd2, "xor");
    check("xor_const", 32'(bus.OUT), 32'd6);
`ifdef ALU_LOGIC_PARITY_EN
    check("xor_parity_const", 32'(bus.parity), 32'd0);
`endif
    step(1'b1, 8'h5A, 8'h5A, 2'd2, "xor_zero");
    check("xor_zero_const", 32'(bus.zero), 32'd1);
    step(1'b1, 8'hF0, 8'hFF, 2'd3, "not_ignb");
    check("not_ignb_const", 32'(bus.OUT), 32'h0F);
    step(1'b1, 8'h00, 8'h00, 2'd3, "not");
    check("not_const", 32'(bus.OUT), 32'd255);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hA5, 8'h3C, 2'd0, "hold");
      check("hold_const", 32'(bus.OUT), 32'd255);
    end

    // Back-to-back: all four opcodes on consecutive cycles.
    step(1'b1, 8'hCC, 8'hAA, 2'd0, "b2b_and");
    step(1'b1, 8'hCC, 8'hAA, 2'd1, "b2b_or");
    step(1'b1, 8'hCC, 8'hAA, 2'd2, "b2b_xor");
    step(1'b1, 8'hCC, 8'hAA, 2'd3, "b2b_not");
    check("b2b_not_const", 32'(bus.OUT), 32'h33);

    // Mid-stream reset: a pending op is dropped and outputs clear at once.
    step(1'b1, 8'h0F, 8'hF0, 2'd1, "pre_rst");
    bus.in_valid = 1'b1;
    bus.A        = 8'h81;
    bus.B        = 8'h18;
    bus.S        = 2'd2;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h81, 8'h18, 2'd2, "post_rst_idle");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           2'($urandom_range(0, 3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
